// File: rtl/rcc_div_sel_ctrl.sv
// Round-robin sequencer for the rcc dynamic divider select: grants one requester,
// drives div_sel, waits for the ratio flop to settle and for div_en lock strobes, then acks.
module rcc_div_sel_ctrl #(
    parameter int NREQ        = 4,
    parameter int SETTLE_CYC  = 4,
    parameter int LOCK_PULSES = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              i_clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] req_sel,
    output logic [NREQ-1:0]   ack,
    output logic [2:0]        div_sel,
    input  logic              div_en,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr
);

    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int PW   = $clog2(LOCK_PULSES + 1);

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_LOCK, S_ACK} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   g_q, g_d;
    logic [2:0]      sel_q, sel_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [PW-1:0]   pls_q, pls_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            busy_q;
    logic            terr_q, terr_d;

    logic            found;
    logic [IW-1:0]   win;
    logic [2:0]      win_sel;

    // Codes 001/010/011 are aliases of /1 and never reach the divider.
    function automatic logic [2:0] canon(input logic [2:0] c);
        return c[2] ? c : 3'b000;
    endfunction

    always_comb begin
        int idx;
        logic [IW-1:0] cand;
        found   = 1'b0;
        win     = '0;
        win_sel = 3'b000;
        idx     = 0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx  = (int'(rr_q) + k) % NREQ;
            cand = IW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (win == IW'(j)) win_sel = canon(req_sel[3*j +: 3]);
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        g_d     = g_q;
        sel_d   = sel_q;
        cyc_d   = cyc_q;
        pls_d   = pls_q;
        ack_d   = '0;
        terr_d  = err_clr ? 1'b0 : terr_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    g_d = win;
                    if (win_sel == sel_q) begin
                        state_d = S_ACK;
                    end else begin
                        sel_d   = win_sel;
                        cyc_d   = '0;
                        state_d = S_APPLY;
                    end
                end
            end
            S_APPLY: begin
                if (cyc_q == CW'(SETTLE_CYC - 1)) begin
                    cyc_d   = '0;
                    pls_d   = '0;
                    state_d = S_LOCK;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_LOCK: begin
                // A lock completing on the last allowed cycle is not a timeout.
                if (div_en && pls_q == PW'(LOCK_PULSES - 1)) begin
                    state_d = S_ACK;
                end else if (cyc_q == CW'(TIMEOUT_CYC - 1)) begin
                    terr_d  = 1'b1;
                    state_d = S_ACK;
                end else begin
                    if (div_en) pls_d = pls_q + 1'b1;
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_ACK: begin
                rr_d    = (g_q == IW'(NREQ - 1)) ? '0 : g_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_ACK) begin
            for (int j = 0; j < NREQ; j++) ack_d[j] = (g_d == IW'(j));
        end
    end

    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            g_q     <= '0;
            sel_q   <= 3'b000;
            cyc_q   <= '0;
            pls_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            g_q     <= g_d;
            sel_q   <= sel_d;
            cyc_q   <= cyc_d;
            pls_q   <= pls_d;
            ack_q   <= ack_d;
            busy_q  <= (state_d != S_IDLE);
            terr_q  <= terr_d;
        end
    end

    assign ack         = ack_q;
    assign div_sel     = sel_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;

endmodule
